// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, register-file geometry and the
// write-back entry carried from the long-latency unit to the register file.
package cpu_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_COUNT  = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for buffered long-latency results; push and pop may
// occur in the same cycle at any occupancy, including full.
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_full    = (o_count == (AW+1)'(DEPTH));
  assign o_empty   = (o_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is left out of reset; the pointers alone define validity,
  // and an unreset array maps onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/wb_scoreboard.sv
// Write-back controller: arbitrates the single register-file write port
// between the ALU and buffered long results, and tracks busy registers.
module wb_scoreboard
  import cpu_pkg::*;
#(
  parameter int XLEN       = cpu_pkg::XLEN,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic                  issue_long,
  input  logic [REG_ADDR_W-1:0] issue_rs1,
  input  logic [REG_ADDR_W-1:0] issue_rs2,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  stall,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  long_valid,
  output logic                  long_ready,
  input  logic [REG_ADDR_W-1:0] long_rd,
  input  logic [XLEN-1:0]       long_data,
  output logic                  write_reg,
  output logic [REG_ADDR_W-1:0] target_reg,
  output logic [XLEN-1:0]       write_rd_data,
  output logic                  idle
);
  localparam int EW = REG_ADDR_W + XLEN;

  logic [REG_COUNT-1:0]        r_busy;
  logic [REG_COUNT-1:0]        w_next_busy;
  logic                        w_alu_wr;
  logic                        w_fifo_wr;
  logic                        w_push;
  logic                        w_issue_set;
  logic [EW-1:0]               w_head;
  logic [REG_ADDR_W-1:0]       w_head_rd;
  logic [XLEN-1:0]             w_head_data;
  logic                        w_full;
  logic                        w_empty;
  logic [$clog2(FIFO_DEPTH):0] w_count;

  assign stall = issue_valid &&
                 (r_busy[issue_rs1] || r_busy[issue_rs2] || r_busy[issue_rd]);
  assign w_issue_set = issue_valid && !stall && issue_long && (issue_rd != '0);

  assign long_ready = !w_full;
  assign w_push     = long_valid && long_ready && (long_rd != '0);
  assign w_alu_wr   = alu_valid && (alu_rd != '0);
  assign w_fifo_wr  = !w_alu_wr && !w_empty;

  assign w_head_rd   = w_head[EW-1:XLEN];
  assign w_head_data = w_head[XLEN-1:0];
  assign idle        = (r_busy == '0) && (w_count == '0);

  wb_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_fifo_wr),
    .i_data  ({long_rd, long_data}),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // NOTE: every signal driven in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    write_reg     = 1'b0;
    target_reg    = '0;
    write_rd_data = '0;
    if (w_alu_wr) begin
      write_reg     = 1'b1;
      target_reg    = alu_rd;
      write_rd_data = alu_data;
    end else if (w_fifo_wr) begin
      write_reg     = 1'b1;
      target_reg    = w_head_rd;
      write_rd_data = w_head_data;
    end
  end

  // Set is applied after clear so it wins if both ever target one bit.
  always_comb begin
    w_next_busy = r_busy;
    if (w_fifo_wr)   w_next_busy[w_head_rd] = 1'b0;
    if (w_issue_set) w_next_busy[issue_rd]  = 1'b1;
    w_next_busy[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_next_busy;
  end
endmodule

// File: tb/tb_wb_scoreboard.sv
// Bench for wb_scoreboard: a queue/array model predicts every output each
// cycle, and directed scenarios pin key values with literal expectations.
module tb_wb_scoreboard;
  import cpu_pkg::*;

  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            issue_valid, issue_long;
  logic [4:0]      issue_rs1, issue_rs2, issue_rd;
  logic            stall;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [31:0]     alu_data;
  logic            long_valid, long_ready;
  logic [4:0]      long_rd;
  logic [31:0]     long_data;
  logic            write_reg;
  logic [4:0]      target_reg;
  logic [31:0]     write_rd_data;
  logic            idle;

  int n_checks = 0;
  int n_errors = 0;

  wb_scoreboard #(.XLEN(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_long(issue_long),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .stall(stall),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .long_valid(long_valid), .long_ready(long_ready),
    .long_rd(long_rd), .long_data(long_data),
    .write_reg(write_reg), .target_reg(target_reg),
    .write_rd_data(write_rd_data), .idle(idle)
  );

  // Standalone FIFO instance to exercise push+pop while full directly.
  logic       f_push = 1'b0, f_pop = 1'b0;
  logic [7:0] f_din = '0, f_dout;
  logic       f_full, f_empty;
  logic [1:0] f_count;
  wb_fifo #(.WIDTH(8), .DEPTH(2)) u_fifo_chk (
    .clk(clk), .rst(rst), .i_push(f_push), .i_pop(f_pop), .i_data(f_din),
    .o_data(f_dout), .o_full(f_full), .o_empty(f_empty), .o_count(f_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [31:0]   m_busy;
  wb_entry     m_q[$];
  logic [31:0] shadow_rf [32];

  function automatic bit m_stall();
    return issue_valid && (m_busy[issue_rs1] || m_busy[issue_rs2] || m_busy[issue_rd]);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = '0;
      m_q.delete();
    end else begin
      bit ready_pre, alu_w, issue_ok;
      ready_pre = (m_q.size() < DEPTH);
      alu_w     = alu_valid && (alu_rd != 0);
      issue_ok  = issue_valid && !m_stall() && issue_long && (issue_rd != 0);
      if (!alu_w && m_q.size() > 0) begin
        m_busy[m_q[0].rd] = 1'b0;
        void'(m_q.pop_front());
      end
      if (long_valid && ready_pre && long_rd != 0)
        m_q.push_back('{rd: long_rd, data: long_data});
      if (issue_ok) m_busy[issue_rd] = 1'b1;
    end
  end

  // One compare process: every non-reset cycle, all outputs against the model.
  always @(negedge clk) begin
    if (!rst) begin
      bit          e_wr;
      logic [4:0]  e_rd;
      logic [31:0] e_data;
      e_wr = 1'b0; e_rd = '0; e_data = '0;
      if (alu_valid && alu_rd != 0) begin
        e_wr = 1'b1; e_rd = alu_rd; e_data = alu_data;
      end else if (m_q.size() > 0) begin
        e_wr = 1'b1; e_rd = m_q[0].rd; e_data = m_q[0].data;
      end
      check("model_stall", stall, m_stall());
      check("model_long_ready", long_ready, m_q.size() < DEPTH);
      check("model_write_reg", write_reg, e_wr);
      check("model_target_reg", target_reg, e_rd);
      check("model_write_data", write_rd_data, e_data);
      check("model_idle", idle, (m_busy == 0) && (m_q.size() == 0));
      if (write_reg) shadow_rf[target_reg] = write_rd_data;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    issue_valid = 0; issue_long = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    long_valid = 0; long_rd = 0; long_data = 0;
  endtask

  task automatic issue(input logic lng, input logic [4:0] rs1, rs2, rd);
    issue_valid = 1; issue_long = lng; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd;
  endtask

  task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    alu_valid = v; alu_rd = rd; alu_data = d;
  endtask

  task automatic lres(input logic v, input logic [4:0] rd, input logic [31:0] d);
    long_valid = v; long_rd = rd; long_data = d;
  endtask

  initial begin
    quiet();
    repeat (2) tick();
    rst = 0;
    #1;
    // Reset state
    check("rst_idle", idle, 1);
    check("rst_long_ready", long_ready, 1);
    check("rst_write_reg", write_reg, 0);
    check("rst_stall", stall, 0);
    tick();

    // RAW on a long result: issue long x5, then add x7,x5,x1
    issue(1, 0, 0, 5);
    #1 check("raw_first_issue_stall", stall, 0);
    tick();
    issue(0, 5, 1, 7);
    #1 check("raw_stall_a", stall, 1);
    tick();
    lres(1, 5, 32'hDEADBEEF);
    #1 check("raw_stall_b", stall, 1);
    tick();
    lres(0, 0, 0);
    #1;
    check("raw_stall_c", stall, 1);
    check("raw_wr_target", target_reg, 5);
    check("raw_wr_data", write_rd_data, 32'hDEADBEEF);
    tick();
    #1;
    check("raw_stall_released", stall, 0);
    check("raw_rf_x5", shadow_rf[5], 32'hDEADBEEF);
    tick();
    quiet();

    // Long x8 behind three ALU writes x9..x11
    issue(1, 0, 0, 8);
    tick();
    quiet();
    alu(1, 9, 32'h9); lres(1, 8, 32'h88);
    tick();
    lres(0, 0, 0); alu(1, 10, 32'hA);
    #1 check("alu_first_tgt", target_reg, 10);
    tick();
    alu(1, 11, 32'hB);
    tick();
    alu(0, 0, 0);
    #1;
    check("x8_after_alu_tgt", target_reg, 8);
    check("x8_not_idle", idle, 0);
    tick();
    #1 check("x8_busy_cleared_idle", idle, 1);
    tick();

    // Back-pressure: ALU holds the port while three long results are offered
    alu(1, 13, 32'hD);
    lres(1, 14, 32'h140);
    tick();
    lres(1, 15, 32'h150);
    tick();
    lres(1, 16, 32'h160);
    #1 check("bp_not_ready_a", long_ready, 0);
    tick();
    #1 check("bp_not_ready_b", long_ready, 0);
    alu(0, 0, 0);
    #1;
    check("bp_full_pop_ready", long_ready, 0);
    check("bp_order_1", target_reg, 14);
    tick();
    #1;
    check("bp_ready_again", long_ready, 1);
    check("bp_order_2", target_reg, 15);
    tick();
    lres(0, 0, 0);
    #1 check("bp_order_3", target_reg, 16);
    tick();
    #1 check("bp_drained", write_reg, 0);
    tick();

    // WAW on x12, and a dropped rd=0 long result
    issue(1, 0, 0, 12);
    tick();
    issue(0, 0, 0, 12);
    lres(1, 0, 32'hFF);
    #1;
    check("waw_stall", stall, 1);
    check("rd0_ready", long_ready, 1);
    tick();
    quiet();
    #1;
    check("rd0_no_write", write_reg, 0);
    check("rd0_busy_kept", idle, 0);
    tick();
    lres(1, 12, 32'h12);
    tick();
    lres(0, 0, 0);
    #1 check("x12_write", target_reg, 12);
    tick();
    #1 check("x12_idle", idle, 1);
    tick();

    // Asynchronous reset with two buffered entries and busy {x5,x6}
    issue(1, 0, 0, 5);
    tick();
    issue(1, 0, 0, 6);
    tick();
    quiet();
    alu(1, 1, 32'h1); lres(1, 5, 32'h55);
    tick();
    lres(1, 6, 32'h66);
    tick();
    lres(0, 0, 0); alu(0, 0, 0);
    issue(0, 5, 6, 0);
    #1;
    check("pre_rst_full", long_ready, 0);
    check("pre_rst_write", write_reg, 1);
    rst = 1;
    #1;
    check("async_rst_write", write_reg, 0);
    check("async_rst_idle", idle, 1);
    check("async_rst_ready", long_ready, 1);
    check("async_rst_stall", stall, 0);
    tick();
    tick();
    rst = 0;
    quiet();
    tick();
    #1 check("post_rst_no_write", write_reg, 0);
    tick();

    // FIFO push+pop while full keeps count and order
    f_push = 1; f_din = 8'hA1;
    tick();
    f_din = 8'hB2;
    tick();
    f_push = 0;
    #1;
    check("fifo_full", f_full, 1);
    check("fifo_count_full", f_count, 2);
    f_push = 1; f_pop = 1; f_din = 8'hC3;
    #1 check("fifo_head_a", f_dout, 8'hA1);
    tick();
    f_push = 0; f_pop = 0;
    #1;
    check("fifo_count_after_pp", f_count, 2);
    check("fifo_still_full", f_full, 1);
    check("fifo_head_b", f_dout, 8'hB2);
    f_pop = 1;
    tick();
    #1 check("fifo_head_c", f_dout, 8'hC3);
    tick();
    f_pop = 0;
    #1 check("fifo_empty", f_empty, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/wb_scoreboard.md
# wb_scoreboard

Write-back controller and register scoreboard that drives the register file's single write port (`write_reg`, `target_reg`, `write_rd_data`). It merges results from the single-cycle ALU path and a variable-latency unit (load/mul/div) and buffers long results while the ALU owns the port. It tracks which architectural registers have a long-latency write outstanding and raises `stall` for any issuing instruction that would read or overwrite one. It sits between execute and the register file and is the only writer of that file.

## Interface
- `XLEN`, 32, datapath width
- `FIFO_DEPTH`, 2, long-result buffer entries (power of two, ≥2)
- `clk` in 1, rising-edge clock
- `rst` in 1, asynchronous, active-high reset
- `issue_valid` in 1, an instruction is attempting to issue this cycle
- `issue_long` in 1, that instruction writes through the long-latency unit
- `issue_rs1`, `issue_rs2`, `issue_rd` in 5 each, source/destination register numbers
- `stall` out 1, issue must hold this cycle
- `alu_valid` in 1, ALU result present (cannot be back-pressured)
- `alu_rd` in 5, `alu_data` in XLEN, ALU destination and value
- `long_valid` in 1, `long_ready` out 1, long-unit result handshake
- `long_rd` in 5, `long_data` in XLEN, long-unit destination and value
- `write_reg` out 1, `target_reg` out 5, `write_rd_data` out XLEN, register file write port
- `idle` out 1, no busy bits set and FIFO empty

## Operation
- Scoreboard: 32-bit `busy` vector; bit 0 permanently 0.
- `stall` = `issue_valid` && (`busy[issue_rs1]` || `busy[issue_rs2]` || `busy[issue_rd]`), evaluated on current register state (combinational). The rd term blocks WAW hazards.
- Set: `issue_valid` && !`stall` && `issue_long` && `issue_rd`≠0 sets `busy[issue_rd]` at the edge.
- Clear: a FIFO entry written to the register file clears `busy[entry.rd]` at the same edge.
- Set and clear of the same bit cannot coincide, because the stall rule forbids it. If both occur anyway, set wins.
- Port arbitration, combinational:
  - `alu_valid` && `alu_rd`≠0 drives the port with the ALU result.
  - Otherwise a non-empty FIFO drives the port from its head, which is popped at the edge.
  - Otherwise `write_reg`=0.
- `long_ready` = FIFO not full. An accepted entry with `long_rd`=0 is dropped and not enqueued.
- There is no direct path from `long_*` to the port. Every long result passes through the FIFO.
- A simultaneous FIFO push and pop is legal at any occupancy, including full (pop frees the slot, but `long_ready` still reflects pre-edge fullness).
- `write_reg` is never 1 with `target_reg`=0.
- While `write_reg`=0, `target_reg` and `write_rd_data` are 0.

## Timing
- Reset values: `busy`=0, FIFO empty, `stall`=0, `long_ready`=1, `write_reg`=0, `target_reg`=0, `write_rd_data`=0, `idle`=1.
- Reset mid-operation discards all buffered results and busy bits. The pipeline flushes alongside.
- ALU result: written at the edge ending the cycle in which it is presented (0 added latency).
- Long result accepted at edge N:
  - with the port free, it is written at edge N+1;
  - the busy bit clears at that edge, and `stall` for its readers deasserts in cycle N+1.
- Each consecutive ALU-valid cycle delays FIFO drain by one cycle. FIFO order is preserved.
- `idle` is combinational from `busy` and FIFO occupancy.

## Structure
- Shared package `cpu_pkg`: `XLEN`, `REG_ADDR_W`=5, `REG_COUNT`=32, and a `wb_entry` typedef (rd, data).
- Sub-module `wb_fifo`: synchronous FIFO, parameterised by width and depth, with push/pop/full/empty/count. It supports simultaneous push and pop.
- The scoreboard, arbitration and stall logic live in the top module.

## Test plan
- Reset then idle: `idle`=1, `long_ready`=1, `write_reg`=0. Assert `rst` asynchronously mid-cycle with 2 FIFO entries and busy={x5,x6}: everything clears immediately, with no write afterwards.
- Issue long to x5 (accepted), then issue `add x7,x5,x1`: `stall`=1 until the cycle after the long result (rd=5, 0xDEADBEEF) is written. The register file then reads x5=0xDEADBEEF.
- Long result for x8 arrives while `alu_valid` is held for 3 cycles (x9..x11): the ALU writes go first, and x8 is written on the 4th edge. `busy[8]` clears at that edge.
- Back-pressure: `alu_valid` held and 3 long results offered: 2 accepted, `long_ready`=0 on the third until the ALU releases. The results are written in order.
- WAW: busy[x12] set, ALU-path issue with rd=12 → `stall`=1. rd=0 long result accepted → nothing written, no busy change.
- Simultaneous push and pop with the FIFO full: count stays at 2, and `long_ready` stays 0 that cycle.
